// File: rtl/wb_master_engine.sv
// wb_master_engine: queued Wishbone classic master for the I2C DUT register bus.
// Commands enter a CMD_DEPTH-deep FIFO. Each command runs as one classic cycle.
// Each command returns exactly one response, in command order.
// A sticky interrupt flag latches rising edges of irq_i.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   cmd_*                 command queue (valid/ready), we/adr/dat/sel payload
//   rsp_*                 response (valid/ready), we echo, read data, error flag
//   cyc_o..sel_o          Wishbone master outputs
//   dat_i, ack_i, err_i   Wishbone slave returns
//   irq_i, irq_clr_i      interrupt input and clear
//   irq_pending_o         sticky interrupt flag
//   busy_o                FSM active or FIFO non-empty
//   cmd_count_o           FIFO occupancy
module wb_master_engine #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]            cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]            cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0]          cmd_sel_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic                             rsp_we_o,
  output logic [DATA_WIDTH-1:0]            rsp_dat_o,
  output logic                             rsp_err_o,
  output logic                             cyc_o,
  output logic                             stb_o,
  output logic                             we_o,
  output logic [ADDR_WIDTH-1:0]            adr_o,
  output logic [DATA_WIDTH-1:0]            dat_o,
  output logic [DATA_WIDTH/8-1:0]          sel_o,
  input  logic [DATA_WIDTH-1:0]            dat_i,
  input  logic                             ack_i,
  input  logic                             err_i,
  input  logic                             irq_i,
  input  logic                             irq_clr_i,
  output logic                             irq_pending_o,
  output logic                             busy_o,
  output logic [$clog2(CMD_DEPTH+1)-1:0]   cmd_count_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_WIDTH = $clog2(CMD_DEPTH + 1);
  localparam int unsigned TMO_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Command FIFO storage (payload only, no reset needed)
  logic                  r_fifo_we  [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_adr [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_dat [CMD_DEPTH];
  logic [SEL_WIDTH-1:0]  r_fifo_sel [CMD_DEPTH];

  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;

  state_t                r_state;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [TMO_WIDTH-1:0]  r_tmo;
  logic                  r_rsp_valid;
  logic                  r_rsp_we;
  logic [DATA_WIDTH-1:0] r_rsp_dat;
  logic                  r_rsp_err;
  logic                  r_busy;
  logic                  r_irq_prev;
  logic                  r_irq_pend;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_WIDTH-1:0]  w_count_nxt;

  state_t                w_state_nxt;
  logic                  w_cyc_nxt;
  logic                  w_we_nxt;
  logic [ADDR_WIDTH-1:0] w_adr_nxt;
  logic [DATA_WIDTH-1:0] w_dat_nxt;
  logic [SEL_WIDTH-1:0]  w_sel_nxt;
  logic [TMO_WIDTH-1:0]  w_tmo_nxt;
  logic                  w_rsp_valid_nxt;
  logic                  w_rsp_we_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_dat_nxt;
  logic                  w_rsp_err_nxt;
  logic                  w_term;
  logic                  w_term_err;

  // FIFO status and handshakes
  assign w_full      = (r_count == CNT_WIDTH'(CMD_DEPTH));
  assign w_empty     = (r_count == '0);
  assign cmd_ready_o = !w_full;
  assign w_push      = cmd_valid_i && !w_full;
  assign w_count_nxt = r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);

  // FIFO payload write
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_we[r_wr_ptr]  <= cmd_we_i;
      r_fifo_adr[r_wr_ptr] <= cmd_adr_i;
      r_fifo_dat[r_wr_ptr] <= cmd_dat_i;
      r_fifo_sel[r_wr_ptr] <= cmd_sel_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      r_count <= w_count_nxt;
    end
  end

  // Next-state and next-output logic for the bus FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_sel_nxt       = r_sel;
    w_tmo_nxt       = r_tmo;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_we_nxt    = r_rsp_we;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
    w_pop           = 1'b0;
    w_term          = 1'b0;
    w_term_err      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = r_fifo_we[r_rd_ptr];
          w_adr_nxt   = r_fifo_adr[r_rd_ptr];
          w_dat_nxt   = r_fifo_we[r_rd_ptr] ? r_fifo_dat[r_rd_ptr] : '0;
          w_sel_nxt   = r_fifo_sel[r_rd_ptr];
          w_tmo_nxt   = '0;
          w_state_nxt = S_BUS;
        end
      end

      S_BUS: begin
        // err beats ack, ack beats timeout
        if (err_i) begin
          w_term     = 1'b1;
          w_term_err = 1'b1;
        end else if (ack_i) begin
          w_term     = 1'b1;
        end else if ((TIMEOUT != 0) && (r_tmo == TMO_WIDTH'(TIMEOUT - 1))) begin
          w_term     = 1'b1;
          w_term_err = 1'b1;
        end else begin
          w_tmo_nxt  = r_tmo + TMO_WIDTH'(1);
        end

        if (w_term) begin
          w_cyc_nxt       = 1'b0;
          w_we_nxt        = 1'b0;
          w_adr_nxt       = '0;
          w_dat_nxt       = '0;
          w_sel_nxt       = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_we_nxt    = r_we;
          w_rsp_err_nxt   = w_term_err;
          // read data is only meaningful on a clean ack of a read
          w_rsp_dat_nxt   = (!w_term_err && !r_we) ? dat_i : '0;
          w_state_nxt     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_tmo       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_sel       <= w_sel_nxt;
      r_tmo       <= w_tmo_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_we    <= w_rsp_we_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
    end
  end

  // Sticky interrupt flag; a new rising edge wins over a clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_irq_prev <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      r_irq_prev <= irq_i;
      if (irq_i && !r_irq_prev) begin
        r_irq_pend <= 1'b1;
      end else if (irq_clr_i) begin
        r_irq_pend <= 1'b0;
      end
    end
  end

  assign cyc_o         = r_cyc;
  assign stb_o         = r_cyc;
  assign we_o          = r_we;
  assign adr_o         = r_adr;
  assign dat_o         = r_dat;
  assign sel_o         = r_sel;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_we_o      = r_rsp_we;
  assign rsp_dat_o     = r_rsp_dat;
  assign rsp_err_o     = r_rsp_err;
  assign irq_pending_o = r_irq_pend;
  assign busy_o        = r_busy;
  assign cmd_count_o   = r_count;

endmodule

// File: tb/tb_wb_master_engine.sv
// Testbench for wb_master_engine: directed command sequences against a
// transaction-level model (expected-response queue, occupancy counters,
// interrupt flag) checked every cycle, plus hand-computed literal checks.
module tb_wb_master_engine;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;
  localparam int TMO    = 255;

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
    logic       sel;
    int         mode;
    int         delay;
    logic [7:0] rdata;
  } txn_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [1:0] cmd_adr_i;
  logic [7:0] cmd_dat_i;
  logic [0:0] cmd_sel_i;
  logic       rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o;
  logic [7:0] rsp_dat_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [0:0] sel_o;
  logic [7:0] dat_i;
  logic       ack_i, err_i, irq_i, irq_clr_i, irq_pending_o, busy_o;
  logic [2:0] cmd_count_o;

  wb_master_engine #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .CMD_DEPTH(4), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
    .irq_i(irq_i), .irq_clr_i(irq_clr_i), .irq_pending_o(irq_pending_o),
    .busy_o(busy_o), .cmd_count_o(cmd_count_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_chk = 0;
  int   n_err = 0;
  txn_t drv;
  txn_t expq[$];
  int   n_acc, n_start, n_cons;
  int   cyc_len, last_len;
  logic prev_cyc;
  logic m_pend, m_prev;
  logic mon_en = 1'b0;
  logic last_we, last_err;
  logic [7:0] last_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_len(input txn_t t);
    return (t.mode == M_NONE) ? TMO : t.delay + 1;
  endfunction

  // Model + slave: every negedge, check DUT against the transaction model,
  // then drive the slave reply and record handshakes for the coming edge.
  initial begin
    txn_t h;
    ack_i = 1'b0; err_i = 1'b0; dat_i = 8'hEE;
    prev_cyc = 1'b0; m_pend = 1'b0; m_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!mon_en) begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = 8'hEE;
        prev_cyc = 1'b0; m_pend = 1'b0; m_prev = 1'b0;
      end else begin
        if (cyc_o && !prev_cyc) begin
          n_start++;
          cyc_len = 0;
        end
        chk("cmd_count", cmd_count_o, n_acc - n_start);
        chk("cmd_ready", cmd_ready_o, (n_acc - n_start) != 4);
        chk("busy", busy_o, (n_acc - n_cons) != 0);
        chk("rsp_valid", rsp_valid_o, (n_start > n_cons) && !cyc_o);
        chk("irq_pending", irq_pending_o, m_pend);
        ack_i = 1'b0; err_i = 1'b0; dat_i = 8'hEE;
        if (cyc_o) begin
          cyc_len++;
          if (expq.size() == 0) chk("cyc_without_cmd", 1, 0);
          else begin
            h = expq[0];
            chk("stb", stb_o, 1);
            chk("we_o", we_o, h.we);
            chk("adr_o", adr_o, h.adr);
            chk("sel_o", sel_o, h.sel);
            chk("dat_o", dat_o, h.we ? h.dat : 8'h00);
            if (h.mode != M_NONE && cyc_len == h.delay + 1) begin
              ack_i = (h.mode == M_ACK) || (h.mode == M_BOTH);
              err_i = (h.mode == M_ERR) || (h.mode == M_BOTH);
              dat_i = h.rdata;
            end
          end
        end else begin
          if (prev_cyc && expq.size() != 0) begin
            chk("cyc_length", cyc_len, exp_len(expq[0]));
            last_len = cyc_len;
          end
          chk("idle_bus", {stb_o, we_o, adr_o, dat_o, sel_o}, 0);
        end
        prev_cyc = cyc_o;
        if (rsp_valid_o) begin
          if (expq.size() == 0) chk("rsp_without_cmd", 1, 0);
          else begin
            h = expq[0];
            chk("rsp_we", rsp_we_o, h.we);
            chk("rsp_err", rsp_err_o, h.mode != M_ACK);
            chk("rsp_dat", rsp_dat_o, (h.mode == M_ACK && !h.we) ? h.rdata : 8'h00);
            last_we = rsp_we_o; last_err = rsp_err_o; last_dat = rsp_dat_o;
            if (rsp_ready_i) begin
              void'(expq.pop_front());
              n_cons++;
            end
          end
        end
        if (cmd_valid_i && cmd_ready_o) begin
          expq.push_back(drv);
          n_acc++;
        end
        if (irq_i && !m_prev) m_pend = 1'b1;
        else if (irq_clr_i) m_pend = 1'b0;
        m_prev = irq_i;
      end
    end
  end

  task automatic offer(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                       input int mode, input int delay, input logic [7:0] rdata);
    drv.we = we; drv.adr = adr; drv.dat = dat; drv.sel = 1'b1;
    drv.mode = mode; drv.delay = delay; drv.rdata = rdata;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = 1'b1;
    cmd_valid_i = 1'b1;
  endtask

  task automatic push(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                      input int mode, input int delay, input logic [7:0] rdata);
    bit ok;
    ok = 1'b0;
    offer(we, adr, dat, mode, delay, rdata);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_i);
      ok = cmd_ready_o;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 2000 && n_cons < n; k++) @(negedge clk_i);
    if (n_cons < n) chk("rsp_timeout", n_cons, n);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0;
    cmd_dat_i = '0; cmd_sel_i = '0; rsp_ready_i = 1'b1;
    irq_i = 1'b0; irq_clr_i = 1'b0;
    n_acc = 0; n_start = 0; n_cons = 0; cyc_len = 0; last_len = 0;
    repeat (3) @(posedge clk_i); #1;
    chk("reset_cyc", cyc_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_cmd_ready", cmd_ready_o, 1);
    chk("reset_count", cmd_count_o, 0);
    chk("reset_busy_irq", {busy_o, irq_pending_o}, 0);
    rst_i = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i); #1;

    // Write adr=2 dat=A5, ack 3 cycles after the first strobe cycle
    push(1'b1, 2'd2, 8'hA5, M_ACK, 3, 8'h00);
    wait_rsp(1);
    chk("wr_cyc_len", last_len, 4);
    chk("wr_rsp", {last_we, last_err, last_dat}, {1'b1, 1'b0, 8'h00});

    // Read adr=1, immediate ack with 3C
    push(1'b0, 2'd1, 8'h00, M_ACK, 0, 8'h3C);
    wait_rsp(2);
    chk("rd_cyc_len", last_len, 1);
    chk("rd_rsp", {last_we, last_err, last_dat}, {1'b0, 1'b0, 8'h3C});

    // Fill: one command parked in RESP plus four queued; sixth must stall
    rsp_ready_i = 1'b0;
    push(1'b1, 2'd0, 8'h11, M_ACK, 0, 8'h00);
    push(1'b0, 2'd3, 8'h00, M_ACK, 2, 8'h77);
    push(1'b1, 2'd1, 8'h22, M_ERR, 1, 8'h00);
    push(1'b0, 2'd2, 8'h00, M_ACK, 1, 8'h99);
    push(1'b1, 2'd3, 8'h33, M_ACK, 0, 8'h00);
    offer(1'b0, 2'd0, 8'h00, M_ACK, 0, 8'hC3);
    repeat (20) @(posedge clk_i); #1;
    chk("full_count", cmd_count_o, 4);
    chk("full_ready", cmd_ready_o, 0);
    chk("full_accepted", n_acc, 7);
    rsp_ready_i = 1'b1;
    push(1'b0, 2'd0, 8'h00, M_ACK, 0, 8'hC3);
    wait_rsp(8);
    chk("fill_last_dat", last_dat, 8'hC3);

    // Timeout, then a normal command
    push(1'b0, 2'd1, 8'h00, M_NONE, 0, 8'h00);
    wait_rsp(9);
    chk("tmo_cyc_len", last_len, 255);
    chk("tmo_err", last_err, 1);
    push(1'b1, 2'd2, 8'h5C, M_ACK, 1, 8'h00);
    wait_rsp(10);
    chk("post_tmo_err", last_err, 0);

    // ack and err together: err wins, no data captured
    push(1'b0, 2'd3, 8'h00, M_BOTH, 2, 8'h5A);
    wait_rsp(11);
    chk("both_err", last_err, 1);
    chk("both_dat", last_dat, 8'h00);

    // Reset in the middle of a bus cycle with another command queued
    push(1'b0, 2'd1, 8'h00, M_NONE, 0, 8'h00);
    push(1'b1, 2'd0, 8'h44, M_ACK, 0, 8'h00);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_i);
      seen = cyc_o;
    end
    chk("rst_pre_cyc", seen, 1);
    @(posedge clk_i); #1;
    chk("rst_pre_count", cmd_count_o, 1);
    mon_en = 1'b0;
    #3 rst_i = 1'b0;
    #1;
    chk("rst_mid_cyc", {cyc_o, stb_o}, 0);
    chk("rst_mid_count", cmd_count_o, 0);
    chk("rst_mid_rsp_valid", rsp_valid_o, 0);
    expq.delete();
    n_acc = 0; n_start = 0; n_cons = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i); #1;
    push(1'b0, 2'd2, 8'h00, M_ACK, 1, 8'h81);
    wait_rsp(1);
    chk("post_rst_dat", last_dat, 8'h81);

    // Interrupt flag
    irq_i = 1'b1; irq_clr_i = 1'b1;
    @(posedge clk_i); #1;
    irq_i = 1'b0; irq_clr_i = 1'b0;
    chk("irq_set_beats_clr", irq_pending_o, 1);
    @(posedge clk_i); #1;
    chk("irq_sticky", irq_pending_o, 1);
    irq_clr_i = 1'b1;
    @(posedge clk_i); #1;
    irq_clr_i = 1'b0;
    chk("irq_cleared", irq_pending_o, 0);
    irq_i = 1'b1;
    @(posedge clk_i); #1;
    chk("irq_rise", irq_pending_o, 1);
    irq_clr_i = 1'b1;
    @(posedge clk_i); #1;
    irq_clr_i = 1'b0;
    repeat (5) @(posedge clk_i); #1;
    chk("irq_held_no_reset", irq_pending_o, 0);
    irq_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
